clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter PRE_CYCLES, default 16: cycles target reset is held before any clock-source change.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64: cycles after the source change (and lock, if required) before target reset is released.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for mmcm_locked after selecting the PLL path.
REQ-004 SHALL have parameter CNT_W, default 16: counter width, sized to hold the largest of the three cycle parameters.
REQ-005 Clock and reset: one clock, usb_clk; reset is synchronous and active-high, named reset.
REQ-006 SHALL have port: usb_clk  input  1  free-running control clock, independent of sys_clock.
REQ-007 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port: req_use_pll  input  1  host-requested PLL path, usb_clk domain.
REQ-009 SHALL have port: j16_sel  input  1  raw DIP switch input, asynchronous.
REQ-010 SHALL have port: mmcm_locked  input  1  raw MMCM lock, asynchronous.
REQ-011 SHALL have port: use_pll  output  1  drives the second-stage mux select.
REQ-012 SHALL have port: j16_sel_sync  output  1  debounced, synchronized switch value forwarded to the first-stage mux.
REQ-013 SHALL have port: target_reset  output  1  active-high reset to logic clocked by sys_clock.
REQ-014 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 SHALL have port: lock_err  output  1  sticky flag, set on lock timeout.
REQ-016 SHALL have port: err_clr  input  1  single-cycle pulse that clears lock_err.

Function
REQ-017 j16_sel and mmcm_locked SHALL each pass through a 2-flop synchronizer before use.
REQ-018 The synchronized j16_sel SHALL be accepted only after it is stable for 256 consecutive cycles; the accepted value is j16_sel_raw_db.
REQ-019 FSM states SHALL be IDLE, RST_PRE, SWITCH, WAIT_LOCK, SETTLE and RELEASE.
REQ-020 IDLE: when req_use_pll != use_pll, or j16_sel_raw_db != j16_sel_sync, the FSM SHALL go to RST_PRE next cycle, assert target_reset and load the counter with PRE_CYCLES-1.
REQ-021 RST_PRE: the counter SHALL decrement each cycle; at 0 the FSM SHALL go to SWITCH.
REQ-022 SWITCH (exactly 1 cycle): use_pll SHALL register the latched request, j16_sel_sync SHALL register the latched debounced value, and the FSM SHALL go to WAIT_LOCK if the new use_pll=1, else to SETTLE.
REQ-023 Request values SHALL be latched on the IDLE->RST_PRE transition; changes to them during the sequence SHALL be ignored until the next return to IDLE.
REQ-024 WAIT_LOCK: the timeout counter SHALL count up from 0; synchronized lock=1 SHALL move the FSM to SETTLE.
REQ-025 WAIT_LOCK timeout: when the counter reaches LOCK_TIMEOUT with no lock, the FSM SHALL set lock_err=1, force use_pll=0 and go to SETTLE.
REQ-026 After a timeout, a request with req_use_pll=1 SHALL NOT restart a sequence while lock_err=1.
REQ-027 SETTLE: the counter SHALL be loaded with SETTLE_CYCLES-1 and decrement; at 0 the FSM SHALL go to RELEASE.
REQ-028 RELEASE (1 cycle): target_reset SHALL deassert and the FSM SHALL return to IDLE.
REQ-029 IDLE loss of lock: in IDLE with use_pll=1, a synchronized lock 1->0 SHALL start a sequence that keeps use_pll=1 and re-waits for lock (RST_PRE->SWITCH->WAIT_LOCK).
REQ-030 target_reset SHALL be high in every state except IDLE.
REQ-031 busy SHALL equal (state != IDLE).
REQ-032 err_clr SHALL clear lock_err; if err_clr and a timeout coincide in the same cycle, set SHALL win.
REQ-033 All counters SHALL saturate and never wrap.
REQ-034 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-035 On reset the FSM SHALL enter RST_PRE with use_pll=0 and j16_sel_sync=0.
REQ-036 On reset target_reset=1, busy=1, lock_err=0, and the counters and debounce SHALL be cleared.
REQ-037 After reset the module SHALL complete a full sequence with the request latched from the current inputs, so the target is always released through RELEASE.
REQ-038 reset asserted mid-sequence SHALL abort the sequence immediately to the reset state.

Verification
REQ-039 Bench: reset released with req_use_pll=0 and j16_sel=0 -> target_reset=1 for PRE+1+SETTLE+1 cycles, then 0, with use_pll=0.
REQ-040 Bench: req_use_pll 0->1, lock rising 100 cycles after SWITCH -> use_pll=1 exactly 16 cycles after the request, target_reset low 64 cycles after the lock is seen.
REQ-041 Bench: req_use_pll=1 with lock never asserted, LOCK_TIMEOUT=200 -> lock_err=1 after 200 WAIT_LOCK cycles, use_pll=0, target released; no retry until err_clr.
REQ-042 Bench: j16_sel toggling every 50 cycles for 1000 cycles, then stable -> no sequence starts until 256 stable cycles, then exactly one sequence runs and j16_sel_sync follows the final value.
REQ-043 Bench: in IDLE with use_pll=1, mmcm_locked dropped for 10 cycles -> target_reset asserts within 3 cycles and releases 64 cycles after lock returns.
REQ-044 Bench: reset asserted in WAIT_LOCK -> next cycle use_pll=0, target_reset=1, lock_err=0.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - sys_clock source switch sequencer: holds target reset around a mux change,
// waits for MMCM lock when the PLL path is chosen, and debounces the J16 source switch.
module clk_switch_ctrl #(
  parameter int PRE_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int CNT_W         = 16
) (
  input  logic usb_clk,
  input  logic reset,
  input  logic req_use_pll,
  input  logic j16_sel,
  input  logic mmcm_locked,
  input  logic err_clr,
  output logic use_pll,
  output logic j16_sel_sync,
  output logic target_reset,
  output logic busy,
  output logic lock_err
);

  localparam int PRE_EFF    = (PRE_CYCLES < 1) ? 1 : PRE_CYCLES;
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int LOCK_EFF   = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;

  localparam logic [CNT_W-1:0] PRE_LOAD    = CNT_W'(PRE_EFF - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_EFF - 1);
  localparam logic [7:0]       DB_LAST     = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    RST_PRE,
    SWITCH,
    WAIT_LOCK,
    SETTLE,
    RELEASE
  } state_t;

  logic [1:0]       j16_meta;
  logic [1:0]       lock_meta;
  logic             j16_s;
  logic             lock_s;
  logic             lock_s_d;
  logic             lock_fall;
  logic [7:0]       db_cnt;
  logic             j16_sel_raw_db;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lat_pll, lat_pll_nxt;
  logic             lat_j16, lat_j16_nxt;
  logic             use_pll_nxt;
  logic             j16_sync_nxt;
  logic             lock_set;
  logic             pll_change;
  logic             sel_change;
  logic             lock_loss;

  always_ff @(posedge usb_clk) begin
    if (reset) begin
      j16_meta  <= 2'b00;
      lock_meta <= 2'b00;
      lock_s_d  <= 1'b0;
    end else begin
      j16_meta  <= {j16_meta[0], j16_sel};
      lock_meta <= {lock_meta[0], mmcm_locked};
      lock_s_d  <= lock_meta[1];
    end
  end

  assign j16_s     = j16_meta[1];
  assign lock_s    = lock_meta[1];
  assign lock_fall = lock_s_d & ~lock_s;

  // Any sample that agrees with the accepted value restarts the 256-cycle stability window.
  always_ff @(posedge usb_clk) begin
    if (reset) begin
      db_cnt         <= '0;
      j16_sel_raw_db <= 1'b0;
    end else if (j16_s == j16_sel_raw_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt         <= '0;
      j16_sel_raw_db <= j16_s;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // A PLL request is ignored while a lock timeout is still flagged.
  assign pll_change = (req_use_pll != use_pll) && !(req_use_pll && lock_err);
  assign sel_change = (j16_sel_raw_db != j16_sel_sync);
  assign lock_loss  = use_pll && lock_fall;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_pll_nxt  = lat_pll;
    lat_j16_nxt  = lat_j16;
    use_pll_nxt  = use_pll;
    j16_sync_nxt = j16_sel_sync;
    lock_set     = 1'b0;
    case (state)
      IDLE: begin
        if (pll_change || sel_change || lock_loss) begin
          state_nxt   = RST_PRE;
          cnt_nxt     = PRE_LOAD;
          lat_pll_nxt = req_use_pll & ~lock_err;
          lat_j16_nxt = j16_sel_raw_db;
        end
      end
      RST_PRE: begin
        if (cnt == '0) begin
          state_nxt    = SWITCH;
          use_pll_nxt  = lat_pll;
          j16_sync_nxt = lat_j16;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SWITCH: begin
        if (use_pll) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else if (cnt >= LOCK_LAST) begin
          state_nxt   = SETTLE;
          cnt_nxt     = SETTLE_LOAD;
          use_pll_nxt = 1'b0;
          lock_set    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = RST_PRE;
        cnt_nxt   = PRE_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so target_reset never glitches on state decode.
  always_ff @(posedge usb_clk) begin
    if (reset) begin
      state        <= RST_PRE;
      cnt          <= PRE_LOAD;
      lat_pll      <= req_use_pll;
      lat_j16      <= 1'b0;
      use_pll      <= 1'b0;
      j16_sel_sync <= 1'b0;
      target_reset <= 1'b1;
      busy         <= 1'b1;
      lock_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lat_pll      <= lat_pll_nxt;
      lat_j16      <= lat_j16_nxt;
      use_pll      <= use_pll_nxt;
      j16_sel_sync <= j16_sync_nxt;
      target_reset <= (state_nxt != IDLE);
      busy         <= (state_nxt != IDLE);
      if (lock_set) begin
        lock_err <= 1'b1;
      end else if (err_clr) begin
        lock_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - self-checking bench for clk_switch_ctrl
module tb_clk_switch_ctrl;

  localparam int PRE = 16;
  localparam int SET = 64;
  localparam int LT  = 200;

  logic usb_clk = 1'b0;
  logic reset = 1'b1;
  logic req_use_pll = 1'b0;
  logic j16_sel = 1'b0;
  logic mmcm_locked = 1'b0;
  logic err_clr = 1'b0;
  logic use_pll, j16_sel_sync, target_reset, busy, lock_err;

  int n_checks = 0;
  int n_fail = 0;
  bit m_use = 1'b0;
  bit m_err = 1'b0;
  bit m_j16 = 1'b0;

  typedef struct {
    bit req;
    int d;
    bit clr;
    bit exp_use;
    bit exp_err;
    int exp_rel;
  } vec_t;

  vec_t vecs[7];

  clk_switch_ctrl #(
    .PRE_CYCLES(PRE), .SETTLE_CYCLES(SET), .LOCK_TIMEOUT(LT), .CNT_W(16)
  ) dut (
    .usb_clk(usb_clk), .reset(reset), .req_use_pll(req_use_pll), .j16_sel(j16_sel),
    .mmcm_locked(mmcm_locked), .err_clr(err_clr), .use_pll(use_pll),
    .j16_sel_sync(j16_sel_sync), .target_reset(target_reset), .busy(busy), .lock_err(lock_err)
  );

  always #5 usb_clk = ~usb_clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    @(negedge usb_clk);
  endtask

  // Reset held for 'hold' edges, then a full start-up sequence of PRE+1+SET+1 reset cycles.
  task automatic reset_seq(input int hold);
    reset = 1'b1;
    req_use_pll = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rst_use_pll", use_pll, 0);
      check("rst_target_reset", target_reset, 1);
      check("rst_busy", busy, 1);
      check("rst_lock_err", lock_err, 0);
      check("rst_j16_sel_sync", j16_sel_sync, 0);
    end
    reset = 1'b0;
    for (int n = 1; n <= PRE + SET + 5; n++) begin
      tick();
      check("boot_target_reset", target_reset, (n <= PRE + SET + 1));
      check("boot_busy", busy, (n <= PRE + SET + 1));
      check("boot_use_pll", use_pll, 0);
    end
    m_use = 1'b0;
    m_err = 1'b0;
    m_j16 = 1'b0;
  endtask

  // One request from IDLE, driven before edge 1; lock (if requested) is driven high after edge d.
  task automatic run_episode(input bit nreq, input int d, input bit clr_to, output int rel);
    int  e;
    int  r;
    bit  tmo;
    bit  old_use;
    old_use = m_use;
    tmo = 1'b0;
    if (nreq) begin
      if (d + 3 <= PRE + 2 + LT) e = (d + 3 > PRE + 3) ? d + 3 : PRE + 3;
      else begin
        tmo = 1'b1;
        e = PRE + 2 + LT;
      end
    end else begin
      e = PRE + 2;
    end
    r = e + SET + 1;
    req_use_pll = nreq;
    if (nreq) mmcm_locked = (d == 0);
    rel = -1;
    for (int n = 1; n <= r + 2; n++) begin
      tick();
      check("ep_target_reset", target_reset, (n < r));
      check("ep_busy", busy, (n < r));
      check("ep_use_pll", use_pll, (n < PRE + 1) ? old_use : ((tmo && n >= e) ? 1'b0 : nreq));
      check("ep_lock_err", lock_err, (tmo && n >= e));
      check("ep_j16_sel_sync", j16_sel_sync, m_j16);
      if (rel < 0 && target_reset === 1'b0) rel = n;
      if (nreq && d > 0 && n == d) mmcm_locked = 1'b1;
      err_clr = clr_to && tmo && (n == e - 1);
    end
    err_clr = 1'b0;
    m_use = tmo ? 1'b0 : nreq;
    m_err = m_err | tmo;
  endtask

  task automatic clear_err();
    req_use_pll = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_lock_err", lock_err, 0);
    repeat (4) begin
      tick();
      check("clr_busy", busy, 0);
    end
    m_err = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle_busy", busy, 0);
  endtask

  initial begin
    int rel;
    int d;

    vecs[0] = '{1'b1, 0,   1'b0, 1'b1, 1'b0, 84};
    vecs[1] = '{1'b0, 0,   1'b0, 1'b0, 1'b0, 83};
    vecs[2] = '{1'b1, 117, 1'b0, 1'b1, 1'b0, 185};
    vecs[3] = '{1'b0, 0,   1'b0, 1'b0, 1'b0, 83};
    vecs[4] = '{1'b1, 215, 1'b0, 1'b1, 1'b0, 283};
    vecs[5] = '{1'b0, 0,   1'b0, 1'b0, 1'b0, 83};
    vecs[6] = '{1'b1, 216, 1'b1, 1'b0, 1'b1, 283};

    reset_seq(3);

    for (int i = 0; i < 7; i++) begin
      run_episode(vecs[i].req, vecs[i].d, vecs[i].clr, rel);
      check("vec_release_edge", rel, vecs[i].exp_rel);
      check("vec_use_pll", use_pll, vecs[i].exp_use);
      check("vec_lock_err", lock_err, vecs[i].exp_err);
    end

    // PLL request still high after the timeout: nothing may start until err_clr.
    repeat (40) begin
      tick();
      check("noretry_busy", busy, 0);
      check("noretry_lock_err", lock_err, 1);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr_lock_err", lock_err, 0);
    check("errclr_busy_edge1", busy, 0);
    tick();
    check("errclr_busy_edge2", busy, 1);
    wait_idle(400);
    check("errclr_use_pll", use_pll, 1);
    m_use = 1'b1;
    m_err = 1'b0;

    // Lock lost for 10 cycles while running from the PLL.
    mmcm_locked = 1'b0;
    for (int n = 1; n <= 90; n++) begin
      tick();
      check("lol_target_reset", target_reset, (n >= 3 && n < 3 + PRE + 2 + SET + 1));
      check("lol_use_pll", use_pll, 1);
      if (n == 10) mmcm_locked = 1'b1;
    end

    run_episode(1'b0, 0, 1'b0, rel);

    // Bouncing J16: toggles every 50 cycles never settle long enough to be accepted.
    for (int i = 0; i < 20; i++) begin
      j16_sel = ~j16_sel;
      repeat (50) begin
        tick();
        check("db_bounce_busy", busy, 0);
      end
    end
    j16_sel = 1'b1;
    for (int n = 1; n <= 345; n++) begin
      tick();
      check("db_busy", busy, (n >= 2 + 256 + 1 && n < 2 + 256 + 1 + PRE + 1 + SET + 1));
      check("db_j16_sel_sync", j16_sel_sync, (n >= 2 + 256 + 1 + PRE));
      check("db_use_pll", use_pll, 0);
    end
    m_j16 = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (m_err) clear_err();
      d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 240));
      run_episode(!m_use, d, 1'($urandom_range(0, 1)), rel);
    end

    // Reset while waiting for a lock that never comes.
    if (m_err) clear_err();
    if (m_use) run_episode(1'b0, 0, 1'b0, rel);
    mmcm_locked = 1'b0;
    repeat (5) tick();
    req_use_pll = 1'b1;
    repeat (PRE + 10) tick();
    check("wl_use_pll", use_pll, 1);
    check("wl_busy", busy, 1);
    reset_seq(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
